// File: rtl/io_map_pkg.sv
// Shared address map and event encoding for the button/LED MMIO block.
package io_map_pkg;

   // Word addresses decoded on the processor data port
   localparam logic [31:0] BTN_ADDR = 32'd4096;
   localparam logic [31:0] LED_ADDR = 32'd4097;

   // Bit position of the sticky overflow flag in the event read word
   localparam int OVF_BIT = 31;

   // Contents of the one-deep event register
   typedef enum logic [1:0] {
      EVT_NONE = 2'd0,
      EVT_UP   = 2'd1,
      EVT_DOWN = 2'd2
   } evt_code_t;

   // Builds the word software sees when it reads the event register
   function automatic logic [31:0] pack_event(input logic ovf, input evt_code_t code);
      logic [31:0] word;
      word          = 32'd0;
      word[OVF_BIT] = ovf;
      word[1:0]     = code;
      return word;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and press-edge pulse
// for one raw mechanical button.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] stable_cnt;
   logic             accept;

   // The debounced level flips once the synchronized input has disagreed
   // with it for DEBOUNCE_CYCLES consecutive cycles.
   assign accept = (sync_2 != level) && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // Count how long the synchronized level has differed from the accepted one
   always_ff @(posedge clock) begin
      if (!reset) begin
         stable_cnt <= '0;
         level      <= 1'b0;
      end else if (sync_2 == level) begin
         stable_cnt <= '0;
      end else if (accept) begin
         stable_cnt <= '0;
         level      <= ~level;
      end else begin
         stable_cnt <= stable_cnt + 1'b1;
      end
   end

   // Single-cycle pulse in the cycle right after the level rises; releases are silent
   always_ff @(posedge clock) begin
      if (!reset) begin
         press <= 1'b0;
      end else begin
         press <= accept && !level;
      end
   end

endmodule

// File: rtl/mmio_button_ctrl.sv
// Memory-mapped glue between the processor data port, the up/down buttons
// and the LED / win-loss register. Each debounced press becomes exactly one
// read-to-clear event for software.
module mmio_button_ctrl
   import io_map_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [31:0] mem_addr,
   input  logic        mem_wen,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] ram_rdata,
   output logic [31:0] q_dmem,
   output logic [15:0] led,
   output logic [1:0]  win_loss,
   output logic        evt_pending
);

   logic      up_level_unused;
   logic      down_level_unused;
   logic      up_press;
   logic      down_press;
   logic      btn_read;
   logic      led_write;
   evt_code_t evt_code;
   logic      evt_ovf;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_up (
      .clock(clock),
      .reset(reset),
      .raw  (btn_up),
      .level(up_level_unused),
      .press(up_press)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_down (
      .clock(clock),
      .reset(reset),
      .raw  (btn_down),
      .level(down_level_unused),
      .press(down_press)
   );

   // Upper write-data bits and the raw debounced levels have no consumer here
   logic unused_bits;
   assign unused_bits = &{1'b0, mem_wdata[31:16], up_level_unused, down_level_unused};

   assign btn_read    = (mem_addr == BTN_ADDR) && !mem_wen;
   assign led_write   = (mem_addr == LED_ADDR) && mem_wen;
   assign evt_pending = (evt_code != EVT_NONE);

   // One-deep event register: a read drains it and may simultaneously accept a
   // new press; otherwise a press that cannot be stored only marks overflow.
   always_ff @(posedge clock) begin
      if (!reset) begin
         evt_code <= EVT_NONE;
         evt_ovf  <= 1'b0;
      end else if (btn_read) begin
         evt_code <= EVT_NONE;
         evt_ovf  <= 1'b0;
         if (up_press && down_press) begin
            evt_ovf <= 1'b1;
         end else if (up_press) begin
            evt_code <= EVT_UP;
         end else if (down_press) begin
            evt_code <= EVT_DOWN;
         end
      end else if (up_press && down_press) begin
         evt_ovf <= 1'b1;
      end else if (up_press || down_press) begin
         if (evt_code != EVT_NONE) begin
            evt_ovf <= 1'b1;
         end else begin
            evt_code <= up_press ? EVT_UP : EVT_DOWN;
         end
      end
   end

   // LED and win/loss latch on writes to the LED address
   always_ff @(posedge clock) begin
      if (!reset) begin
         led      <= 16'd0;
         win_loss <= 2'd0;
      end else if (led_write) begin
         led      <= mem_wdata[15:0];
         win_loss <= mem_wdata[1:0];
      end
   end

   // Return the event word at the button address, RAM data everywhere else
   always_comb begin
      q_dmem = ram_rdata;
      if (btn_read) begin
         q_dmem = pack_event(evt_ovf, evt_code);
      end
   end

endmodule

// File: tb/tb_mmio_button_ctrl.sv
// Self-checking bench for mmio_button_ctrl: directed scenarios plus random
// button/bus traffic compared against a cycle-level behavioural model.
module tb_mmio_button_ctrl;

   localparam int DB = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        btn_up;
   logic        btn_down;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] q_dmem;
   logic [15:0] led;
   logic [1:0]  win_loss;
   logic        evt_pending;

   int checks = 0;
   int errors = 0;

   // Model state
   bit          m_valid = 1'b0;
   bit          m_s1[2];
   bit          m_s2[2];
   bit          m_deb[2];
   bit          m_pulse[2];
   bit          hq[2][$];
   logic [1:0]  m_code;
   logic        m_ovf;
   logic [15:0] m_led;
   logic [1:0]  m_wl;

   // Last observed DUT outputs
   logic [31:0] last_q;
   logic [15:0] last_led;
   logic [1:0]  last_wl;
   logic        last_evt;

   mmio_button_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (3)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .mem_addr   (mem_addr),
      .mem_wen    (mem_wen),
      .mem_wdata  (mem_wdata),
      .ram_rdata  (ram_rdata),
      .q_dmem     (q_dmem),
      .led        (led),
      .win_loss   (win_loss),
      .evt_pending(evt_pending)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the reference model across one rising edge
   task automatic modelEdge(input logic rst_n, input logic up_raw, input logic dn_raw,
                            input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
      bit  pu, pd, rd, sync_now, all_diff;
      bit  raws[2];
      if (!rst_n) begin
         m_valid = 1'b1;
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_pulse[b] = 0;
            hq[b].delete();
         end
         m_code = 2'd0; m_ovf = 1'b0; m_led = 16'd0; m_wl = 2'd0;
         return;
      end
      pu = m_pulse[0];
      pd = m_pulse[1];
      rd = (addr == 32'd4096) && !wen;
      if (rd) begin
         m_code = 2'd0;
         m_ovf  = 1'b0;
         if (pu && pd) m_ovf = 1'b1;
         else if (pu)  m_code = 2'd1;
         else if (pd)  m_code = 2'd2;
      end else if (pu && pd) begin
         m_ovf = 1'b1;
      end else if (pu || pd) begin
         if (m_code != 2'd0) m_ovf = 1'b1;
         else m_code = pu ? 2'd1 : 2'd2;
      end
      if (wen && addr == 32'd4097) begin
         m_led = wdata[15:0];
         m_wl  = wdata[1:0];
      end
      raws[0] = up_raw;
      raws[1] = dn_raw;
      for (int b = 0; b < 2; b++) begin
         sync_now  = m_s2[b];
         m_s2[b]   = m_s1[b];
         m_s1[b]   = raws[b];
         m_pulse[b] = 0;
         hq[b].push_back(sync_now);
         if (hq[b].size() > DB) void'(hq[b].pop_front());
         if (hq[b].size() == DB) begin
            all_diff = 1;
            for (int i = 0; i < DB; i++)
               if (hq[b][i] == m_deb[b]) all_diff = 0;
            if (all_diff) begin
               m_deb[b]   = ~m_deb[b];
               hq[b].delete();
               m_pulse[b] = m_deb[b];
            end
         end
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then clock
   task automatic applyStimulus(input logic rst_n, input logic up, input logic dn,
                                input logic [31:0] addr, input logic wen,
                                input logic [31:0] wdata, input logic [31:0] ram);
      logic [31:0] exp_q;
      reset = rst_n; btn_up = up; btn_down = dn;
      mem_addr = addr; mem_wen = wen; mem_wdata = wdata; ram_rdata = ram;
      #1;
      last_q = q_dmem; last_led = led; last_wl = win_loss; last_evt = evt_pending;
      if (m_valid) begin
         exp_q = ((addr == 32'd4096) && !wen) ? {m_ovf, 29'd0, m_code} : ram;
         checkOutput("model_q_dmem", q_dmem, exp_q);
         checkOutput("model_led", {16'd0, led}, {16'd0, m_led});
         checkOutput("model_win_loss", {30'd0, win_loss}, {30'd0, m_wl});
         checkOutput("model_evt_pending", {31'd0, evt_pending}, {31'd0, (m_code != 2'd0)});
      end
      modelEdge(rst_n, up, dn, addr, wen, wdata);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle(input int n, input logic up, input logic dn);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, up, dn, 32'd16, 1'b0, 32'd0, $urandom);
   endtask

   task automatic readBtn(input logic up, input logic dn);
      applyStimulus(1'b1, up, dn, 32'd4096, 1'b0, 32'd0, $urandom);
   endtask

   initial begin
      int up_dur, dn_dur, sel;
      logic up_lvl, dn_lvl;
      logic [31:0] addr, wdata;
      logic wen, rst_n;

      reset = 1'b0; btn_up = 0; btn_down = 0;
      mem_addr = 0; mem_wen = 0; mem_wdata = 0; ram_rdata = 0;
      @(negedge clock);
      applyStimulus(1'b0, 0, 0, 32'd0, 1'b0, 32'd0, 32'h0);
      applyStimulus(1'b0, 0, 0, 32'd0, 1'b0, 32'd0, 32'h0);

      // Reset state
      readBtn(0, 0);
      checkOutput("reset_q_dmem", last_q, 32'h0);
      checkOutput("reset_led", {16'd0, last_led}, 32'h0);
      checkOutput("reset_win_loss", {30'd0, last_wl}, 32'h0);
      checkOutput("reset_evt_pending", {31'd0, last_evt}, 32'h0);

      // Held up press gives one event, then reads as empty
      idle(10, 1, 0);
      readBtn(1, 0);
      checkOutput("up_press_read", last_q, 32'h1);
      readBtn(1, 0);
      checkOutput("up_second_read", last_q, 32'h0);
      idle(10, 0, 0);

      // Short glitch on down is filtered
      idle(2, 0, 1);
      idle(10, 0, 0);
      readBtn(0, 0);
      checkOutput("glitch_no_event", last_q, 32'h0);

      // Second press while one is pending sets overflow and keeps the first
      idle(10, 1, 0);
      idle(10, 1, 1);
      readBtn(1, 1);
      checkOutput("overflow_read", last_q, 32'h80000001);
      readBtn(1, 1);
      checkOutput("overflow_cleared", last_q, 32'h0);
      idle(10, 0, 0);

      // Read in the same cycle the press pulse fires
      idle(6, 0, 1);
      readBtn(0, 1);
      checkOutput("read_with_pulse", last_q, 32'h0);
      readBtn(0, 1);
      checkOutput("read_after_pulse", last_q, 32'h2);
      idle(10, 0, 0);

      // LED register writes, ignored button write, LED address reads RAM
      applyStimulus(1'b1, 0, 0, 32'd4097, 1'b1, 32'h0000A5A6, 32'h0);
      idle(1, 0, 0);
      checkOutput("led_write", {16'd0, last_led}, 32'h0000A5A6);
      checkOutput("win_loss_write", {30'd0, last_wl}, 32'h2);
      applyStimulus(1'b1, 0, 0, 32'd4096, 1'b1, 32'hFFFF_FFFF, 32'h0);
      idle(1, 0, 0);
      checkOutput("btn_write_ignored", {16'd0, last_led}, 32'h0000A5A6);
      applyStimulus(1'b1, 0, 0, 32'd4097, 1'b0, 32'h0, 32'hDEADBEEF);
      checkOutput("led_addr_reads_ram", last_q, 32'hDEADBEEF);

      // Reset with an event pending and a button held through it
      applyStimulus(1'b1, 0, 0, 32'd4097, 1'b1, 32'h000000FF, 32'h0);
      idle(10, 1, 0);
      checkOutput("pending_before_reset", {31'd0, last_evt}, 32'h1);
      applyStimulus(1'b0, 1, 0, 32'd16, 1'b0, 32'd0, 32'h0);
      readBtn(1, 0);
      checkOutput("post_reset_q", last_q, 32'h0);
      checkOutput("post_reset_led", {16'd0, last_led}, 32'h0);
      checkOutput("post_reset_wl", {30'd0, last_wl}, 32'h0);
      checkOutput("post_reset_evt", {31'd0, last_evt}, 32'h0);
      idle(6, 1, 0);
      checkOutput("held_not_yet", {31'd0, last_evt}, 32'h0);
      idle(1, 1, 0);
      checkOutput("held_fresh_press", {31'd0, last_evt}, 32'h1);
      readBtn(1, 0);
      checkOutput("held_fresh_read", last_q, 32'h1);
      idle(10, 0, 0);

      // Random traffic against the model
      up_lvl = 0; dn_lvl = 0; up_dur = 0; dn_dur = 0;
      for (int c = 0; c < 2000; c++) begin
         if (up_dur == 0) begin
            up_lvl = $urandom_range(0, 1);
            up_dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
         end
         if (dn_dur == 0) begin
            dn_lvl = $urandom_range(0, 1);
            dn_dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 14);
         end
         up_dur--; dn_dur--;
         sel   = $urandom_range(0, 99);
         wen   = 1'b0;
         wdata = $urandom;
         if (sel < 40)      addr = 32'd4096;
         else if (sel < 50) begin addr = 32'd4097; wen = 1'b1; end
         else if (sel < 55) begin addr = 32'd4096; wen = 1'b1; end
         else if (sel < 60) addr = 32'd4097;
         else begin addr = $urandom; wen = $urandom_range(0, 1); end
         rst_n = ($urandom_range(0, 299) != 0);
         applyStimulus(rst_n, up_lvl, dn_lvl, addr, wen, wdata, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
